// File: rtl/pla_sweep_checker_pkg.sv
// Shared types and constants for the PLA sweep checker.
package pla_pkg;

    localparam int PLA_N_IN  = 3;
    localparam int PLA_N_OUT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } pla_sweep_state_e;

    // Width of a full truth-table image: one N_OUT slot per input code.
    function automatic int tt_width(input int n_in, input int n_out);
        return (1 << n_in) * n_out;
    endfunction

endpackage

// File: rtl/pla_sweep_checker_if.sv
// Handshake/data bundle between the sweep checker, the PLA and the requester.
interface pla_sweep_checker_if
    import pla_pkg::*;
#(
    parameter int N_IN  = PLA_N_IN,
    parameter int N_OUT = PLA_N_OUT
) ();

    localparam int TTW = tt_width(N_IN, N_OUT);

    logic                start;
    logic [TTW-1:0]      expected;
    logic [N_IN-1:0]     pla_in;
    logic [N_OUT-1:0]    pla_out;
    logic                busy;
    logic                done;
    logic                pass;
    logic [TTW-1:0]      truth_table;
    logic [N_IN:0]       mismatch_cnt;
    logic [N_IN-1:0]     first_fail;
    logic                first_fail_vld;

    // Requester side (also closes the PLA loop: it supplies pla_out).
    modport master (
        output start, expected, pla_out,
        input  pla_in, busy, done, pass, truth_table, mismatch_cnt,
               first_fail, first_fail_vld
    );

    // Checker side.
    modport slave (
        input  start, expected, pla_out,
        output pla_in, busy, done, pass, truth_table, mismatch_cnt,
               first_fail, first_fail_vld
    );

endinterface

// File: rtl/pla_sweep_checker.sv
// PLA self-test: sweeps every input code, samples the PLA after SETTLE idle
// cycles, builds the truth table and compares it against a latched golden image.
// Optional macro PLA_SWEEP_FIRST_FAIL_EN enables lowest-failing-code tracking;
// without it first_fail/first_fail_vld are tied to 0.
module pla_sweep_checker
    import pla_pkg::*;
#(
    parameter int N_IN   = PLA_N_IN,
    parameter int N_OUT  = PLA_N_OUT,
    parameter int SETTLE = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    pla_sweep_checker_if.slave  bus
);

    localparam int TTW = tt_width(N_IN, N_OUT);

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_SETTLE = 2'(pla_pkg::SETTLE);
    localparam logic [1:0] ST_SAMPLE = 2'(SAMPLE);
    localparam logic [1:0] ST_DONE   = 2'(DONE);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [N_IN-1:0]   r_idx;
    logic [N_IN-1:0]   r_pla_in;
    logic [TTW-1:0]    r_exp;
    logic [TTW-1:0]    r_tt;
    logic [N_IN:0]     r_mis;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;

    logic [N_OUT-1:0]  w_slot_exp;
    logic              w_miss;
    logic [N_IN:0]     w_mis_next;
    logic              w_accept;

    assign w_accept   = (r_state == ST_IDLE) && bus.start;
    assign w_slot_exp = r_exp[r_idx*N_OUT +: N_OUT];
    assign w_miss     = (bus.pla_out != w_slot_exp);
    assign w_mis_next = r_mis + {{N_IN{1'b0}}, w_miss};

    // Sweep FSM: drive a code, wait SETTLE+1 cycles, sample, advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_pla_in <= '0;
            r_exp    <= '0;
            r_tt     <= '0;
            r_mis    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state  <= ST_SETTLE;
                        r_pla_in <= '0;
                        r_idx    <= '0;
                        r_cnt    <= SETTLE_CNT;
                        r_tt     <= '0;
                        r_mis    <= '0;
                        r_pass   <= 1'b0;
                        r_exp    <= bus.expected;
                        r_busy   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) r_state <= ST_SAMPLE;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                ST_SAMPLE: begin
                    r_tt[r_idx*N_OUT +: N_OUT] <= bus.pla_out;
                    r_mis <= w_mis_next;
                    if (&r_idx) begin
                        // pla_in stays on the last code until the next start.
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (w_mis_next == '0);
                    end else begin
                        r_idx    <= r_idx + 1'b1;
                        r_pla_in <= r_idx + 1'b1;
                        r_cnt    <= SETTLE_CNT;
                        r_state  <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef PLA_SWEEP_FIRST_FAIL_EN
    logic [N_IN-1:0] r_ff;
    logic            r_ffv;

    // Remember the first (lowest, since codes ascend) failing input code.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ff  <= '0;
            r_ffv <= 1'b0;
        end else if (w_accept) begin
            r_ffv <= 1'b0;
        end else if ((r_state == ST_SAMPLE) && w_miss && !r_ffv) begin
            r_ff  <= r_idx;
            r_ffv <= 1'b1;
        end
    end

    assign bus.first_fail     = r_ff;
    assign bus.first_fail_vld = r_ffv;
`else
    assign bus.first_fail     = '0;
    assign bus.first_fail_vld = 1'b0;
`endif

    assign bus.pla_in       = r_pla_in;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.pass         = r_pass;
    assign bus.truth_table  = r_tt;
    assign bus.mismatch_cnt = r_mis;

endmodule

// File: tb/tb_pla_sweep_checker.sv
// Directed bench: two checkers (SETTLE=2 and SETTLE=0), each closing the loop
// through a behavioural PLA: out[0]=in0&in1, out[1]=in1|in2 -> table 16'hEAE0.
module tb_pla_sweep_checker;
    import pla_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] expected = '0;
    logic        sel = 1'b0;     // 0: SETTLE=2 checker, 1: SETTLE=0 checker

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pla_sweep_checker_if #(.N_IN(3), .N_OUT(2)) if2 ();
    pla_sweep_checker_if #(.N_IN(3), .N_OUT(2)) if0 ();

    assign if2.start    = start & ~sel;
    assign if0.start    = start & sel;
    assign if2.expected = expected;
    assign if0.expected = expected;
    assign if2.pla_out  = {if2.pla_in[1] | if2.pla_in[2], if2.pla_in[0] & if2.pla_in[1]};
    assign if0.pla_out  = {if0.pla_in[1] | if0.pla_in[2], if0.pla_in[0] & if0.pla_in[1]};

    pla_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2));
    pla_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));

    // Observed signals of the selected checker.
    wire        o_busy = sel ? if0.busy : if2.busy;
    wire        o_done = sel ? if0.done : if2.done;
    wire        o_pass = sel ? if0.pass : if2.pass;
    wire [2:0]  o_pin  = sel ? if0.pla_in : if2.pla_in;
    wire [15:0] o_tt   = sel ? if0.truth_table : if2.truth_table;
    wire [3:0]  o_mis  = sel ? if0.mismatch_cnt : if2.mismatch_cnt;
    wire [2:0]  o_ff   = sel ? if0.first_fail : if2.first_fail;
    wire        o_ffv  = sel ? if0.first_fail_vld : if2.first_fail_vld;

`ifdef PLA_SWEEP_FIRST_FAIL_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    // Start a sweep and return the edge (accept edge = 1) at which done went high.
    // With hold=1 start stays asserted every cycle until done is seen.
    task automatic sweep(input logic [15:0] exp, input bit hold, output int lat);
        expected = exp;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        lat = 1;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (o_done) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_cmp++;
            if ({o_busy, o_done, o_pass, o_pin, o_tt, o_mis, o_ff, o_ffv} !== 30'd0) begin
                n_bad++;
                $display("FAIL reset sel=%0d: busy=%b done=%b pass=%b pla_in=%0d tt=%h mis=%0d ff=%0d ffv=%b, want all 0",
                         s, o_busy, o_done, o_pass, o_pin, o_tt, o_mis, o_ff, o_ffv);
            end
        end
        sel = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_pass;
        int lat;
        sel = 1'b0;
        sweep(16'hEAE0, 1'b0, lat);
        n_cmp++;
        if (lat !== 33) begin n_bad++; $display("FAIL pass_latency: got %0d want 33", lat); end
        n_cmp++;
        if ({o_busy, o_pass, o_mis, o_tt, o_ffv} !== {1'b1, 1'b1, 4'd0, 16'hEAE0, 1'b0}) begin
            n_bad++;
            $display("FAIL pass_result: busy=%b pass=%b mis=%0d tt=%h ffv=%b want 1 1 0 eae0 0",
                     o_busy, o_pass, o_mis, o_tt, o_ffv);
        end
        @(negedge clk);
        n_cmp++;
        if ({o_busy, o_done, o_pass, o_pin} !== {1'b0, 1'b0, 1'b1, 3'd7}) begin
            n_bad++;
            $display("FAIL pass_after: busy=%b done=%b pass=%b pla_in=%0d want 0 0 1 7",
                     o_busy, o_done, o_pass, o_pin);
        end
    endtask

    task automatic test_mismatch_one;
        int lat;
        sel = 1'b0;
        sweep(16'hE6E0, 1'b0, lat);
        n_cmp++;
        if ({o_pass, o_mis, o_tt} !== {1'b0, 4'd1, 16'hEAE0} || lat !== 33) begin
            n_bad++;
            $display("FAIL mismatch_one: pass=%b mis=%0d tt=%h lat=%0d want 0 1 eae0 33", o_pass, o_mis, o_tt, lat);
        end
        n_cmp++;
        if ({o_ff, o_ffv} !== (FF_EN ? {3'd5, 1'b1} : 4'd0)) begin
            n_bad++;
            $display("FAIL first_fail_one: ff=%0d ffv=%b (feature=%0d)", o_ff, o_ffv, FF_EN);
        end
    endtask

    task automatic test_all_zero;
        int lat;
        sel = 1'b0;
        sweep(16'h0000, 1'b0, lat);
        n_cmp++;
        if ({o_pass, o_mis} !== {1'b0, 4'd6}) begin
            n_bad++;
            $display("FAIL all_zero: pass=%b mis=%0d want 0 6", o_pass, o_mis);
        end
        n_cmp++;
        if ({o_ff, o_ffv} !== (FF_EN ? {3'd2, 1'b1} : 4'd0)) begin
            n_bad++;
            $display("FAIL first_fail_zero: ff=%0d ffv=%b (feature=%0d)", o_ff, o_ffv, FF_EN);
        end
    endtask

    task automatic test_start_held;
        int lat;
        int extra;
        sel = 1'b1;
        sweep(16'hEAE0, 1'b1, lat);
        n_cmp++;
        if (lat !== 17 || o_pass !== 1'b1) begin
            n_bad++;
            $display("FAIL held_start: lat=%0d pass=%b want 17 1", lat, o_pass);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_busy || o_done) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin n_bad++; $display("FAIL no_restart: busy/done cycles=%0d want 0", extra); end
    endtask

    task automatic test_back_to_back;
        int lat;
        sel = 1'b1;
        sweep(16'hEAE0, 1'b0, lat);
        start = 1'b1;              // asserted during DONE: must be ignored
        @(negedge clk);
        n_cmp++;
        if ({o_busy, o_done} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_idle: busy=%b done=%b want 0 0", o_busy, o_done);
        end
        @(negedge clk);            // accepted on the first IDLE edge
        start = 1'b0;
        n_cmp++;
        if ({o_busy, o_pin, o_pass} !== {1'b1, 3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_accept: busy=%b pla_in=%0d pass=%b want 1 0 0", o_busy, o_pin, o_pass);
        end
        lat = 1;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (o_done) break;
        end
        n_cmp++;
        if (lat !== 17 || o_pass !== 1'b1 || o_tt !== 16'hEAE0) begin
            n_bad++;
            $display("FAIL b2b_second: lat=%0d pass=%b tt=%h want 17 1 eae0", lat, o_pass, o_tt);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int dones;
        sel = 1'b0;
        expected = 16'hEAE0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);            // edge 1: accept
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk); // edges 2..9
        @(negedge clk);
        n_cmp++;
        if (o_pin !== 3'd2) begin n_bad++; $display("FAIL pre_reset_pla_in: got %0d want 2", o_pin); end
        rst_n = 1'b0;
        @(posedge clk);            // edge 10
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({o_busy, o_done, o_pin, o_tt} !== 21'd0) begin
            n_bad++;
            $display("FAIL mid_reset: busy=%b done=%b pla_in=%0d tt=%h want 0 0 0 0", o_busy, o_done, o_pin, o_tt);
        end
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_done || o_busy) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin n_bad++; $display("FAIL no_resume: busy/done cycles=%0d want 0", dones); end
        sweep(16'hEAE0, 1'b0, lat);
        n_cmp++;
        if (lat !== 33 || o_pass !== 1'b1 || o_mis !== 4'd0) begin
            n_bad++;
            $display("FAIL after_reset_sweep: lat=%0d pass=%b mis=%0d want 33 1 0", lat, o_pass, o_mis);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_mismatch_one();
        test_all_zero();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
